// File: rtl/question_gen_if.sv
// Question bus between question_gen, the RNG counter and the answer checker.
// master = question_gen side, slave = environment (RNG, player, checker).
interface question_gen_if;
  logic [3:0] count;
  logic       rng_en;
  logic       start;
  logic       busy;
  logic       q_valid;
  logic       q_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [1:0] op_sel;
  logic [7:0] answer;
  logic [3:0] q_num;
  logic       done;

  modport master (
    input  count, start, q_ready,
    output rng_en, busy, q_valid, op_a, op_b, op_sel, answer, q_num, done
  );

  modport slave (
    output count, start, q_ready,
    input  rng_en, busy, q_valid, op_a, op_b, op_sel, answer, q_num, done
  );
endinterface

// File: rtl/question_gen.sv
// Mental-math question generator: samples the free-running RNG count into two
// operands and an operator, computes the answer and offers it over valid/ready.
module question_gen #(
  parameter int GAP           = 3,
  parameter int NUM_QUESTIONS = 10,
  parameter int ENABLE_MUL    = 1
) (
  input  logic           clk,
  input  logic           reset,
  question_gen_if.master bus
);

  typedef enum logic [2:0] {IDLE, WAIT_B, SAMPLE_OP, CALC, PRESENT, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t     r_state;
  state_t     w_next;

  logic [3:0] r_gap;
  logic [3:0] r_a_raw;
  logic [3:0] r_b_raw;
  logic [1:0] r_op;
  logic       r_rng_en;
  logic       r_busy;
  logic       r_q_valid;
  logic [3:0] r_op_a;
  logic [3:0] r_op_b;
  logic [1:0] r_op_sel;
  logic [7:0] r_answer;
  logic [3:0] r_q_num;
  logic       r_done;

  logic       w_accept;
  logic       w_latch_b;
  logic       w_dec;
  logic       w_sample;
  logic       w_calc;
  logic       w_xfer;
  logic       w_last;
  logic       w_swap;
  logic [3:0] w_q_num_nx;
  logic [1:0] w_op_map;
  logic [3:0] w_op_a;
  logic [3:0] w_op_b;
  logic [7:0] w_answer;

  assign w_q_num_nx = r_q_num + 4'd1;
  assign w_last     = (w_q_num_nx == 4'(NUM_QUESTIONS));
  assign w_swap     = (r_a_raw < r_b_raw);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (bus.start && !r_done) w_next = WAIT_B;
      WAIT_B:    if (r_gap == 4'd0) w_next = SAMPLE_OP;
      SAMPLE_OP: w_next = CALC;
      CALC:      w_next = PRESENT;
      PRESENT:   if (bus.q_ready) w_next = w_last ? DONE : IDLE;
      DONE:      w_next = DONE;
      default:   w_next = IDLE;
    endcase
  end

  // Output/control decode: one strobe per register update in the datapath.
  always_comb begin
    w_accept  = 1'b0;
    w_latch_b = 1'b0;
    w_dec     = 1'b0;
    w_sample  = 1'b0;
    w_calc    = 1'b0;
    w_xfer    = 1'b0;
    case (r_state)
      IDLE:      w_accept = bus.start && !r_done;
      WAIT_B: begin
        w_latch_b = (r_gap == 4'd0);
        w_dec     = (r_gap != 4'd0);
      end
      SAMPLE_OP: w_sample = 1'b1;
      CALC:      w_calc   = 1'b1;
      PRESENT:   w_xfer   = bus.q_ready;
      default:   ;
    endcase
  end

  // Operator from the low count bits; 11 folds onto add, mul folds onto sub when disabled.
  always_comb begin
    case (bus.count[1:0])
      2'b01:   w_op_map = OP_SUB;
      2'b10:   w_op_map = (ENABLE_MUL != 0) ? OP_MUL : OP_SUB;
      default: w_op_map = OP_ADD;
    endcase
  end

  always_comb begin
    w_op_a   = r_a_raw;
    w_op_b   = r_b_raw;
    w_answer = {4'd0, r_a_raw} + {4'd0, r_b_raw};
    case (r_op)
      OP_SUB: begin
        w_op_a   = w_swap ? r_b_raw : r_a_raw;
        w_op_b   = w_swap ? r_a_raw : r_b_raw;
        w_answer = {4'd0, (w_swap ? (r_b_raw - r_a_raw) : (r_a_raw - r_b_raw))};
      end
      OP_MUL:  w_answer = {4'd0, r_a_raw} * {4'd0, r_b_raw};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap     <= '0;
      r_a_raw   <= '0;
      r_b_raw   <= '0;
      r_op      <= OP_ADD;
      r_rng_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_q_valid <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_sel  <= OP_ADD;
      r_answer  <= '0;
      r_q_num   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_rng_en <= 1'b1;
      if (w_accept) begin
        r_a_raw <= bus.count;
        r_gap   <= 4'(GAP - 1);
        r_busy  <= 1'b1;
      end
      if (w_dec)     r_gap   <= r_gap - 4'd1;
      if (w_latch_b) r_b_raw <= bus.count;
      if (w_sample)  r_op    <= w_op_map;
      if (w_calc) begin
        r_op_a    <= w_op_a;
        r_op_b    <= w_op_b;
        r_op_sel  <= r_op;
        r_answer  <= w_answer;
        r_q_valid <= 1'b1;
      end
      if (w_xfer) begin
        r_q_valid <= 1'b0;
        r_busy    <= 1'b0;
        r_q_num   <= w_q_num_nx;
        if (w_last) r_done <= 1'b1;
      end
    end
  end

  assign bus.rng_en  = r_rng_en;
  assign bus.busy    = r_busy;
  assign bus.q_valid = r_q_valid;
  assign bus.op_a    = r_op_a;
  assign bus.op_b    = r_op_b;
  assign bus.op_sel  = r_op_sel;
  assign bus.answer  = r_answer;
  assign bus.q_num   = r_q_num;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_question_gen.sv
// Directed bench for question_gen: default build, a no-multiply build and a
// two-question game build share clock, reset and the RNG count.
module tb_question_gen;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       start_m, start_n, start_g;
  logic       ready_m, ready_n, ready_g;
  int         n_cmp;
  int         n_bad;

  question_gen_if if_m ();
  question_gen_if if_n ();
  question_gen_if if_g ();

  assign if_m.count = count;  assign if_m.start = start_m;  assign if_m.q_ready = ready_m;
  assign if_n.count = count;  assign if_n.start = start_n;  assign if_n.q_ready = ready_n;
  assign if_g.count = count;  assign if_g.start = start_g;  assign if_g.q_ready = ready_g;

  question_gen #(.GAP(3), .NUM_QUESTIONS(10), .ENABLE_MUL(1)) u_main (
    .clk(clk), .reset(reset), .bus(if_m.master));
  question_gen #(.GAP(3), .NUM_QUESTIONS(10), .ENABLE_MUL(0)) u_nomul (
    .clk(clk), .reset(reset), .bus(if_n.master));
  question_gen #(.GAP(3), .NUM_QUESTIONS(2), .ENABLE_MUL(1)) u_game (
    .clk(clk), .reset(reset), .bus(if_g.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start_m = v;
      1: start_n = v;
      default: start_g = v;
    endcase
  endtask

  task automatic set_ready(input int inst, input logic v);
    case (inst)
      0: ready_m = v;
      1: ready_n = v;
      default: ready_g = v;
    endcase
  endtask

  // Start at edge k with count=a, b at k+3, opc at k+4; returns after edge k+5.
  task automatic issue(input int inst, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] opc);
    @(negedge clk); count = a; set_start(inst, 1'b1);
    @(negedge clk); set_start(inst, 1'b0); count = 4'd0;
    @(negedge clk);
    @(negedge clk); count = b;
    @(negedge clk); count = opc;
    @(negedge clk); count = 4'd0;
    n_cmp++;
    if (if_m.q_valid !== 1'b0 || if_n.q_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL q_valid_early inst=%0d got m=%b n=%b want 0", inst, if_m.q_valid, if_n.q_valid);
    end
    @(negedge clk);
  endtask

  task automatic accept(input int inst);
    set_ready(inst, 1'b1);
    @(negedge clk);
    set_ready(inst, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    n_cmp++;
    if ({if_m.rng_en, if_m.busy, if_m.q_valid, if_m.op_a, if_m.op_b, if_m.op_sel,
         if_m.answer, if_m.q_num, if_m.done} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got rng_en=%b q_valid=%b q_num=%0d want all 0",
               if_m.rng_en, if_m.q_valid, if_m.q_num);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (if_m.rng_en !== 1'b0) begin
      n_bad++; $display("FAIL rng_en_before_edge got %b want 0", if_m.rng_en);
    end
    @(negedge clk);
    n_cmp++;
    if (if_m.rng_en !== 1'b1 || if_m.q_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rng_en_first_edge got rng_en=%b q_valid=%b want 1/0", if_m.rng_en, if_m.q_valid);
    end
  endtask

  task automatic test_add;
    issue(0, 4'd5, 4'd7, 4'd3);
    n_cmp++;
    if ({if_m.q_valid, if_m.busy} !== 2'b11) begin
      n_bad++; $display("FAIL add_valid got valid=%b busy=%b want 1/1", if_m.q_valid, if_m.busy);
    end
    n_cmp++;
    if ({if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer} !== {4'd5, 4'd7, 2'b00, 8'd12}) begin
      n_bad++;
      $display("FAIL add_question got a=%0d b=%0d sel=%0d ans=%0d want 5 7 0 12",
               if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer);
    end
    accept(0);
    n_cmp++;
    if ({if_m.q_valid, if_m.busy, if_m.q_num} !== {1'b0, 1'b0, 4'd1}) begin
      n_bad++;
      $display("FAIL add_xfer got valid=%b busy=%b q_num=%0d want 0 0 1", if_m.q_valid, if_m.busy, if_m.q_num);
    end
    n_cmp++;
    if (if_m.answer !== 8'd12) begin
      n_bad++; $display("FAIL add_hold got ans=%0d want 12", if_m.answer);
    end
  endtask

  task automatic test_sub;
    issue(0, 4'd4, 4'd9, 4'd1);
    n_cmp++;
    if ({if_m.q_valid, if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer} !==
        {1'b1, 4'd9, 4'd4, 2'b01, 8'd5}) begin
      n_bad++;
      $display("FAIL sub_swap got v=%b a=%0d b=%0d sel=%0d ans=%0d want 1 9 4 1 5",
               if_m.q_valid, if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer);
    end
    accept(0);
    issue(0, 4'd6, 4'd6, 4'd1);
    n_cmp++;
    if ({if_m.q_valid, if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer} !==
        {1'b1, 4'd6, 4'd6, 2'b01, 8'd0}) begin
      n_bad++;
      $display("FAIL sub_equal got v=%b a=%0d b=%0d sel=%0d ans=%0d want 1 6 6 1 0",
               if_m.q_valid, if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer);
    end
    accept(0);
    n_cmp++;
    if (if_m.q_num !== 4'd3) begin
      n_bad++; $display("FAIL sub_q_num got %0d want 3", if_m.q_num);
    end
  endtask

  task automatic test_mul;
    issue(0, 4'd15, 4'd15, 4'd2);
    n_cmp++;
    if ({if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer} !== {4'd15, 4'd15, 2'b10, 8'd225}) begin
      n_bad++;
      $display("FAIL mul_max got a=%0d b=%0d sel=%0d ans=%0d want 15 15 2 225",
               if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer);
    end
    accept(0);
    issue(1, 4'd15, 4'd15, 4'd2);
    n_cmp++;
    if ({if_n.q_valid, if_n.op_sel, if_n.answer} !== {1'b1, 2'b01, 8'd0}) begin
      n_bad++;
      $display("FAIL nomul_sub got v=%b sel=%0d ans=%0d want 1 1 0", if_n.q_valid, if_n.op_sel, if_n.answer);
    end
    accept(1);
    n_cmp++;
    if ({if_n.q_num, if_m.q_num} !== {4'd1, 4'd4}) begin
      n_bad++; $display("FAIL mul_q_num got n=%0d m=%0d want 1 4", if_n.q_num, if_m.q_num);
    end
  endtask

  task automatic test_backpressure;
    issue(0, 4'd2, 4'd3, 4'd0);
    for (int i = 0; i < 10; i++) begin
      count   = 4'(i * 7 + 1);
      start_m = i[0];
      @(negedge clk);
      n_cmp++;
      if ({if_m.q_valid, if_m.busy, if_m.op_a, if_m.op_b, if_m.op_sel, if_m.answer, if_m.q_num} !==
          {1'b1, 1'b1, 4'd2, 4'd3, 2'b00, 8'd5, 4'd4}) begin
        n_bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b busy=%b a=%0d b=%0d ans=%0d q=%0d want 1 1 2 3 5 4",
                 i, if_m.q_valid, if_m.busy, if_m.op_a, if_m.op_b, if_m.answer, if_m.q_num);
      end
    end
    start_m = 1'b0;
    accept(0);
    n_cmp++;
    if ({if_m.q_valid, if_m.busy, if_m.q_num} !== {1'b0, 1'b0, 4'd5}) begin
      n_bad++;
      $display("FAIL bp_xfer got v=%b busy=%b q_num=%0d want 0 0 5", if_m.q_valid, if_m.busy, if_m.q_num);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({if_m.q_valid, if_m.busy, if_m.q_num} !== {1'b0, 1'b0, 4'd5}) begin
      n_bad++;
      $display("FAIL bp_idle got v=%b busy=%b q_num=%0d want 0 0 5", if_m.q_valid, if_m.busy, if_m.q_num);
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk); count = 4'd8; start_m = 1'b1;
    @(negedge clk); start_m = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({if_m.rng_en, if_m.busy, if_m.q_valid, if_m.op_a, if_m.op_b, if_m.op_sel,
         if_m.answer, if_m.q_num, if_m.done} !== 28'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs got rng_en=%b busy=%b q_num=%0d ans=%0d want all 0",
               if_m.rng_en, if_m.busy, if_m.q_num, if_m.answer);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_m.rng_en, if_m.q_valid, if_m.busy, if_m.q_num} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL midreset_release got rng_en=%b v=%b busy=%b q_num=%0d want 1 0 0 0",
               if_m.rng_en, if_m.q_valid, if_m.busy, if_m.q_num);
    end
  endtask

  task automatic test_game_end;
    int xfers;
    xfers   = 0;
    start_g = 1'b1;
    ready_g = 1'b1;
    for (int i = 0; i < 40; i++) begin
      count = 4'(i * 5 + 3);
      @(negedge clk);
      if (if_g.q_valid === 1'b1) xfers++;
    end
    n_cmp++;
    if (xfers != 2) begin
      n_bad++; $display("FAIL game_transfers got %0d want 2", xfers);
    end
    n_cmp++;
    if ({if_g.done, if_g.q_num, if_g.q_valid, if_g.busy} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL game_done got done=%b q_num=%0d v=%b busy=%b want 1 2 0 0",
               if_g.done, if_g.q_num, if_g.q_valid, if_g.busy);
    end
    start_g = 1'b0;
    ready_g = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    count   = 4'd0;
    start_m = 1'b0; start_n = 1'b0; start_g = 1'b0;
    ready_m = 1'b0; ready_n = 1'b0; ready_g = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_backpressure;
    test_mid_reset;
    test_game_end;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
